chunk_sum: RTL
==============

# chunk_sum

Downstream consumer stage for generator-style blocks such as the even-Fibonacci generator. It accepts a signed 32-bit value stream over a ready/valid handshake and groups consecutive values into chunks of a run-time size. For each chunk it emits the wrapped 32-bit sum and the element count. When the upstream stream ends, it flushes any partial chunk and then emits a done beat. The downstream side uses the same start/ready/valid/done protocol as the upstream generators, so blocks can be chained.

## Interface
Parameters:
- none; the chunk size is a run-time input captured on `__start`.

Ports:
- `__clock` input 1: sole clock; all state updates on the rising edge.
- `__reset` input 1: asynchronous, active-low reset.
- `__start` input 1: capture `chunk`, clear accumulators and begin; takes precedence over all other activity.
- `chunk` input signed 32: chunk size; sampled only when `__start` is high.
- `__in_valid` input 1: upstream beat present.
- `__in_done` input 1: qualifies an upstream beat as an end-of-stream marker; `__in_0` is ignored on such a beat.
- `__in_0` input signed 32: upstream data value.
- `__in_ready` output 1: combinational; equals (state==ACCUM) && (!__valid || __ready) && !__start.
- `__ready` input 1: downstream can take the output.
- `__valid` output 1: output registers are valid.
- `__done` output 1: end-of-stream beat; asserted only together with `__valid`.
- `__output_0` output signed 32: chunk sum.
- `__output_1` output signed 32: chunk element count.

## Operation
- States: IDLE, ACCUM, FLUSH.
- Internal registers: `_chunk`, `_acc` (signed 32), `_cnt` (signed 32).
- Reset (`__reset`=0, asynchronous):
  - state IDLE; `__valid`, `__done`, `__output_0`, `__output_1`, `_acc`, `_cnt`, `_chunk` = 0.
- Every edge with `__ready`=1: `__valid` <= 0 and `__done` <= 0, unless overridden by a new emit in the same edge.
- `__start`=1:
  - `_chunk` <= chunk; `_acc`, `_cnt` <= 0; `__valid`, `__done` <= 0.
  - If chunk <= 0: `__valid` and `__done` <= 1, state IDLE (immediate empty termination).
  - Otherwise state ACCUM.
  - Any in-flight chunk is discarded.
- ACCUM, data accept (`__in_valid && __in_ready && !__in_done`):
  - If `_cnt`+1 == `_chunk`: `__output_0` <= `_acc`+`__in_0`, `__output_1` <= `_cnt`+1, `__valid` <= 1; `_acc`, `_cnt` <= 0.
  - Else: `_acc` <= `_acc`+`__in_0`, `_cnt` <= `_cnt`+1.
- ACCUM, done accept (`__in_valid && __in_ready && __in_done`):
  - If `_cnt` > 0: emit `__output_0`=`_acc`, `__output_1`=`_cnt`, `__valid`=1, `__done`=0; clear `_acc`/`_cnt`; state FLUSH.
  - If `_cnt` == 0: emit `__valid`=1, `__done`=1; state IDLE.
- FLUSH: when (!__valid || __ready), emit `__valid`=1, `__done`=1, state IDLE. `__output_0`/`__output_1` hold their last values.
- IDLE: `__in_ready`=0; the block waits for `__start`.
- Arithmetic: two's-complement addition, wrapping modulo 2^32; no saturation or overflow flag.

## Timing
- Output latency: a chunk's result is valid the cycle after the edge that accepts its last element.
- Throughput: one upstream beat per cycle while downstream keeps `__ready` high, including back-to-back chunk emits.
- Backpressure:
  - While `__valid`=1 and `__ready`=0, the outputs hold stable and `__in_ready`=0.
  - No upstream beat is accepted, so nothing is lost.
- Done sequencing:
  - A partial flush occupies one output beat and the done beat follows on a later beat; the two are never merged.
  - Minimum spacing between them is 1 cycle when `__ready` stays high.
- Simultaneous `__start` and an upstream beat: the beat is not accepted, because `__in_ready`=0 during start.
- `__in_valid`=0: `__in_done` and `__in_0` are don't-care.
- Reset mid-chunk: the partial sum is lost; outputs read 0 asynchronously.

## Test plan
- chunk=2, upstream 0,2,8,34 then done, `__ready`=1 → (sum 2, count 2), (42, 2), then a done beat; 3 valid beats total.
- chunk=3, same stream → (10, 3), partial (34, 1), then a done beat on the next cycle.
- chunk=0 on `__start` → the next cycle shows `__valid`=1, `__done`=1; `__in_ready` stays 0.
- chunk=1, stream 5,6 with `__ready` held low 4 cycles after the first emit → `__output_0`=5 holds for 4 cycles, `__in_ready`=0, 6 is accepted only after `__ready` rises; no value is dropped.
- chunk=2, inputs 0x7FFFFFFF and 1 → `__output_0`=0x80000000 (-2147483648), `__output_1`=2.
- chunk=4, accept 3 values, then pulse `__reset` low → all outputs 0 immediately; then `__start` with chunk=2 and inputs 1,1 → (2, 2), with no stale accumulation.

Source files
------------

// File: rtl/chunk_sum_if.sv
// chunk_sum_if: start/ready/valid/done stream bundle between a chunk_sum and its neighbours.
interface chunk_sum_if;
    logic               __start;
    logic signed [31:0] chunk;
    logic               __in_valid;
    logic               __in_done;
    logic signed [31:0] __in_0;
    logic               __in_ready;
    logic               __ready;
    logic               __valid;
    logic               __done;
    logic signed [31:0] __output_0;
    logic signed [31:0] __output_1;

    modport master (
        output __start, chunk, __in_valid, __in_done, __in_0, __ready,
        input  __in_ready, __valid, __done, __output_0, __output_1
    );

    modport slave (
        input  __start, chunk, __in_valid, __in_done, __in_0, __ready,
        output __in_ready, __valid, __done, __output_0, __output_1
    );
endinterface

// File: rtl/chunk_sum.sv
// chunk_sum: groups a signed stream into run-time sized chunks, emits wrapped sum and count per chunk,
// flushes a partial chunk at end of stream and then emits a separate done beat.
module chunk_sum (
    input logic       __clock,
    input logic       __reset,
    chunk_sum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] chunk_q, chunk_d, acc_q, acc_d, cnt_q, cnt_d;
    logic signed [31:0] out0_q, out0_d, out1_q, out1_d;
    logic               valid_q, valid_d, done_q, done_d;
    logic               accept, empty_start;
    logic signed [31:0] cnt_inc, acc_sum;

    assign bus.__in_ready = state_q == ACCUM && (!valid_q || bus.__ready) && !bus.__start;
    assign bus.__valid    = valid_q;
    assign bus.__done     = done_q;
    assign bus.__output_0 = out0_q;
    assign bus.__output_1 = out1_q;

    assign accept      = bus.__in_valid && bus.__in_ready;
    assign empty_start = bus.chunk <= 32'sd0;
    assign cnt_inc     = cnt_q + 32'sd1;
    assign acc_sum     = acc_q + bus.__in_0;

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        valid_d = valid_q && !bus.__ready;
        done_d  = done_q && !bus.__ready;
        if (bus.__start) begin
            chunk_d = bus.chunk;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = empty_start;
            done_d  = empty_start;
            state_d = empty_start ? IDLE : ACCUM;
        end else if (accept && bus.__in_done) begin
            // a partial chunk goes out first; the done beat follows from FLUSH
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            if (cnt_q > 32'sd0) begin
                out0_d  = acc_q;
                out1_d  = cnt_q;
                done_d  = 1'b0;
                state_d = FLUSH;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (accept) begin
            if (cnt_inc == chunk_q) begin
                out0_d  = acc_sum;
                out1_d  = cnt_inc;
                valid_d = 1'b1;
                done_d  = 1'b0;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end else if (state_q == FLUSH && (!valid_q || bus.__ready)) begin
            valid_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge __clock or negedge __reset) begin
        if (!__reset) begin
            state_q <= IDLE;
            chunk_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
endmodule
